// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: flush plus input and result handshakes of the stage.
// master: upstream/downstream side; slave: the immediate stage.
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output flush,
    output in_valid,
    output in_instr,
    output in_pc,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_imm,
    input  out_fmt,
    input  out_target,
    input  out_illegal
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_instr,
    input  in_pc,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_imm,
    output out_fmt,
    output out_target,
    output out_illegal
  );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RISC-V immediate decode with B/J/AUIPC target.
// Ports: clk, rst_n (async, active low), bus (flush, in_*, out_* handshake).
module imm_gen_stage #(
  parameter int XLEN      = 32,
  parameter int TARGET_EN = 1
) (
  input logic            clk,
  input logic            rst_n,
  imm_gen_stage_if.slave bus
);

  localparam logic IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_ZIMM = 3'd6,
    FMT_ILL  = 3'd7
  } fmt_e;

  logic [31:0]     instr;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            shift;
  logic [31:0]     i_imm;
  logic [31:0]     s_imm;
  logic [31:0]     b_imm;
  logic [31:0]     u_imm;
  logic [31:0]     j_imm;
  logic [31:0]     imm32;
  fmt_e            fmt;
  logic            tgt_en;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] tgt_d;

  logic            valid_q;
  logic [XLEN-1:0] imm_q;
  fmt_e            fmt_q;
  logic [XLEN-1:0] tgt_q;
  logic            ill_q;
  logic            ready;
  logic            take;

  assign instr = bus.in_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign shift = (f3 == 3'b001) || (f3 == 3'b101);

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  // Every immediate fits in 32 bits with the sign in bit 31; shamt and
  // zimm values are small and positive, so one sign extension serves all.
  always_comb begin
    imm32  = '0;
    fmt    = FMT_NONE;
    tgt_en = 1'b0;
    unique case (opc)
      OPC_OPIMM: begin
        fmt = FMT_I;
        if (!shift) imm32 = i_imm;
        else if (IS64) imm32 = {26'b0, instr[25:20]};
        else if (instr[25]) fmt = FMT_ILL;
        else imm32 = {27'b0, instr[24:20]};
      end
      OPC_OPIMMW: begin
        fmt = IS64 ? FMT_I : FMT_ILL;
        if (IS64) imm32 = shift ? {27'b0, instr[24:20]} : i_imm;
      end
      OPC_LOAD, OPC_JALR, OPC_FENCE: begin
        fmt   = FMT_I;
        imm32 = i_imm;
      end
      OPC_SYSTEM: begin
        fmt   = f3[2] ? FMT_ZIMM : FMT_I;
        imm32 = f3[2] ? {27'b0, instr[19:15]} : i_imm;
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = s_imm;
      end
      OPC_BRANCH: begin
        fmt    = FMT_B;
        imm32  = b_imm;
        tgt_en = 1'b1;
      end
      OPC_LUI: begin
        fmt   = FMT_U;
        imm32 = u_imm;
      end
      OPC_AUIPC: begin
        fmt    = FMT_U;
        imm32  = u_imm;
        tgt_en = 1'b1;
      end
      OPC_JAL: begin
        fmt    = FMT_J;
        imm32  = j_imm;
        tgt_en = 1'b1;
      end
      OPC_OP: fmt = FMT_NONE;
      OPC_OPW: fmt = IS64 ? FMT_NONE : FMT_ILL;
      default: fmt = FMT_ILL;
    endcase
  end

  assign imm_d = XLEN'($signed(imm32));
  assign sum   = bus.in_pc + imm_d;
  assign tgt_d = ((TARGET_EN != 0) && tgt_en) ? sum : '0;

  assign ready = !valid_q || bus.out_ready;
  assign take  = bus.in_valid && ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      fmt_q   <= FMT_NONE;
      tgt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      if (bus.flush) valid_q <= 1'b0;
      else if (take) valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;
      if (take) begin
        imm_q <= imm_d;
        fmt_q <= fmt;
        tgt_q <= tgt_d;
        ill_q <= (fmt == FMT_ILL);
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_fmt     = fmt_q;
  assign bus.out_target  = tgt_q;
  assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: drives XLEN=32 and XLEN=64 stages with one stream;
// a negedge monitor pops per-instance scoreboards on each output transfer.
module tb_imm_gen_stage;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [31:0] i32;
    logic [2:0]  f32;
    logic [31:0] t32;
    logic [63:0] i64;
    logic [2:0]  f64;
    logic [63:0] t64;
  } vec_t;

  localparam int N = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   rnd_mode = 1'b0;
  vec_t tv [N];
  int   q32 [$];
  int   q64 [$];

  imm_gen_stage_if #(.XLEN(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64)) b64 ();

  imm_gen_stage #(.XLEN(32), .TARGET_EN(1)) d32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );
  imm_gen_stage #(.XLEN(64), .TARGET_EN(1)) d64 (
    .clk(clk), .rst_n(rst_n), .bus(b64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic vec_t mk(
    input logic [31:0] instr, input logic [63:0] pc,
    input logic [31:0] i32, input logic [2:0] f32,
    input logic [31:0] t32, input logic [63:0] i64,
    input logic [2:0] f64, input logic [63:0] t64);
    vec_t v;
    v.instr = instr; v.pc = pc;
    v.i32 = i32; v.f32 = f32; v.t32 = t32;
    v.i64 = i64; v.f64 = f64; v.t64 = t64;
    return v;
  endfunction

  task automatic chk(input string n, input int idx,
                     input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s idx=%0d got=%h want=%h t=%0t",
                  n, idx, a, e, $time);
  endtask

  task automatic set_in(input bit v, input int idx);
    b32.in_valid = v;
    b64.in_valid = v;
    b32.in_instr = tv[idx].instr;
    b64.in_instr = tv[idx].instr;
    b32.in_pc    = tv[idx].pc[31:0];
    b64.in_pc    = tv[idx].pc;
  endtask

  task automatic set_rdy(input bit r);
    b32.out_ready = r;
    b64.out_ready = r;
  endtask

  task automatic set_flush(input bit f);
    b32.flush = f;
    b64.flush = f;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer vector idx until accepted; returns just after the capture edge.
  task automatic send(input int idx);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    set_in(1'b1, idx);
    while (!done) begin
      @(negedge clk);
      if (b32.in_ready && !b32.flush) begin
        q32.push_back(idx);
        q64.push_back(idx);
        done = 1'b1;
      end else if (++n > 60) begin
        chk("send_timeout", idx, 64'd1, 64'd0);
        done = 1'b1;
      end
      sync();
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_v32"}, 0, b32.out_valid, 0);
    chk({n, "_i32"}, 0, b32.out_imm, 0);
    chk({n, "_f32"}, 0, b32.out_fmt, 0);
    chk({n, "_t32"}, 0, b32.out_target, 0);
    chk({n, "_l32"}, 0, b32.out_illegal, 0);
    chk({n, "_r32"}, 0, b32.in_ready, 1);
    chk({n, "_v64"}, 0, b64.out_valid, 0);
    chk({n, "_i64"}, 0, b64.out_imm, 0);
    chk({n, "_f64"}, 0, b64.out_fmt, 0);
    chk({n, "_t64"}, 0, b64.out_target, 0);
    chk({n, "_l64"}, 0, b64.out_illegal, 0);
    chk({n, "_r64"}, 0, b64.in_ready, 1);
  endtask

  always @(negedge clk) begin
    int k;
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) chk("d32_spurious", -1, 1, 0);
      else begin
        k = q32.pop_front();
        chk("d32_imm", k, b32.out_imm, tv[k].i32);
        chk("d32_fmt", k, b32.out_fmt, tv[k].f32);
        chk("d32_tgt", k, b32.out_target, tv[k].t32);
        chk("d32_ill", k, b32.out_illegal, tv[k].f32 == 3'd7);
      end
    end
    if (rst_n && b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) chk("d64_spurious", -1, 1, 0);
      else begin
        k = q64.pop_front();
        chk("d64_imm", k, b64.out_imm, tv[k].i64);
        chk("d64_fmt", k, b64.out_fmt, tv[k].f64);
        chk("d64_tgt", k, b64.out_target, tv[k].t64);
        chk("d64_ill", k, b64.out_illegal, tv[k].f64 == 3'd7);
      end
    end
  end

  initial begin
    int c0;
    int c1;
    int gap;
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PCW = 64'hFFFF_FFFF_FFFF_FFFC;
    tv[0]  = mk(32'hFFF00093, 64'h1000, 32'hFFFFFFFF, 1, 0,
                M1, 1, 0);
    tv[1]  = mk(32'hFE000EE3, 64'h100, 32'hFFFFFFFC, 3, 32'hFC,
                64'hFFFF_FFFF_FFFF_FFFC, 3, 64'hFC);
    tv[2]  = mk(32'h0000006F, PCW, 0, 5, 32'hFFFFFFFC,
                0, 5, PCW);
    tv[3]  = mk(32'h0080006F, PCW, 8, 5, 4, 8, 5, 4);
    tv[4]  = mk(32'h800000B7, 64'h40, 32'h80000000, 4, 0,
                64'hFFFF_FFFF_8000_0000, 4, 0);
    tv[5]  = mk(32'hFFFFF097, 64'h2000, 32'hFFFFF000, 4, 32'h1000,
                64'hFFFF_FFFF_FFFF_F000, 4, 64'h1000);
    tv[6]  = mk(32'h03F09093, 0, 0, 7, 0, 64'h3F, 1, 0);
    tv[7]  = mk(32'h41F0D093, 0, 32'h1F, 1, 0, 64'h1F, 1, 0);
    tv[8]  = mk(32'h0010009B, 0, 0, 7, 0, 64'h1, 1, 0);
    tv[9]  = mk(32'h03F0909B, 0, 0, 7, 0, 64'h1F, 1, 0);
    tv[10] = mk(32'h300FD073, 64'h80, 32'h1F, 6, 0, 64'h1F, 6, 0);
    tv[11] = mk(32'h00000000, 64'h80, 0, 7, 0, 0, 7, 0);
    tv[12] = mk(32'hFE112C23, 64'h80, 32'hFFFFFFF8, 2, 0,
                64'hFFFF_FFFF_FFFF_FFF8, 2, 0);
    tv[13] = mk(32'h002081B3, 64'h80, 0, 0, 0, 0, 0, 0);
    tv[14] = mk(32'h002081BB, 64'h80, 0, 7, 0, 0, 0, 0);
    tv[15] = mk(32'h80002083, 64'h80, 32'hFFFFF800, 1, 0,
                64'hFFFF_FFFF_FFFF_F800, 1, 0);
    tv[16] = mk(32'h300020F3, 64'h80, 32'h300, 1, 0, 64'h300, 1, 0);

    set_in(1'b0, 0);
    set_rdy(1'b0);
    set_flush(1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync();

    set_rdy(1'b1);
    c0 = cyc;
    for (int i = 0; i < N; i++) send(i);
    c1 = cyc;
    set_in(1'b0, 0);
    chk("throughput", 0, c1 - c0, N);
    @(negedge clk);
    @(negedge clk);
    chk("drain_v32", 0, b32.out_valid, 0);
    chk("drain_q", 0, q32.size() + q64.size(), 0);

    sync();
    set_rdy(1'b0);
    send(1);
    set_in(1'b1, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_ready", c, b32.in_ready, 0);
      chk("hold_valid", c, b64.out_valid, 1);
      chk("hold_imm32", c, b32.out_imm, tv[1].i32);
      chk("hold_tgt32", c, b32.out_target, tv[1].t32);
      chk("hold_imm64", c, b64.out_imm, tv[1].i64);
      chk("hold_fmt64", c, b64.out_fmt, tv[1].f64);
      sync();
    end
    set_rdy(1'b1);
    send(4);
    set_in(1'b0, 0);
    chk("b_next_v", 4, b32.out_valid, 1);
    chk("b_next_i64", 4, b64.out_imm, tv[4].i64);
    @(negedge clk);
    sync();
    @(negedge clk);
    chk("bp_drain", 0, b64.out_valid, 0);

    sync();
    set_rdy(1'b0);
    send(0);
    set_in(1'b1, 5);
    set_flush(1'b1);
    sync();
    set_flush(1'b0);
    set_in(1'b0, 0);
    chk("flush_v32", 0, b32.out_valid, 0);
    chk("flush_v64", 0, b64.out_valid, 0);
    chk("flush_q", 0, q32.size(), 1);
    q32.delete();
    q64.delete();
    set_in(1'b1, 6);
    set_flush(1'b1);
    @(negedge clk);
    chk("flush_rdy", 0, b32.in_ready, 1);
    sync();
    set_flush(1'b0);
    set_in(1'b0, 0);
    chk("flush2_v32", 0, b32.out_valid, 0);
    chk("flush2_v64", 0, b64.out_valid, 0);
    set_rdy(1'b1);
    send(7);
    set_in(1'b0, 0);
    @(negedge clk);

    sync();
    rnd_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      gap = $urandom_range(0, 1);
      set_in(1'b0, 0);
      repeat (gap) sync();
      send($urandom_range(0, N - 1));
    end
    set_in(1'b0, 0);
    rnd_mode = 1'b0;
    @(posedge clk);
    #2;
    set_rdy(1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (q32.size() == 0 && q64.size() == 0) break;
    end
    chk("rand_q32", 0, q32.size(), 0);
    chk("rand_q64", 0, q64.size(), 0);

    sync();
    set_rdy(1'b0);
    send(12);
    set_in(1'b1, 13);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    q32.delete();
    q64.delete();
    set_in(1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    set_rdy(1'b1);
    send(15);
    set_in(1'b0, 0);
    repeat (3) @(negedge clk);
    chk("final_q", 0, q32.size() + q64.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  always begin
    bit r;
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      r = 1'($urandom_range(0, 1));
      b32.out_ready = r;
      b64.out_ready = r;
    end
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Pipelined, parametrised immediate-generation stage between fetch and execute.
- Decodes the instruction opcode itself rather than taking a format select from the control unit.
- Produces an XLEN-wide extended immediate, a format code, and a PC-relative target for B, J and AUIPC.
- Outputs are registered behind a valid/ready handshake with flush support.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- TARGET_EN, 1, 1 computes out_target; 0 ties out_target to 0.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of the held entry and of the same-cycle input.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  raw instruction.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 ZIMM, 7 ILLEGAL.
- out_target  output  XLEN  in_pc + imm for B/J/AUIPC, else 0.
- out_illegal  output  1  opcode not recognised for this XLEN.

Behaviour:
- Reset: rst_n low clears all outputs asynchronously to 0 (out_valid=0, out_imm=0, out_fmt=0, out_target=0, out_illegal=0). in_ready is combinational and equals 1 while out_valid=0.
- Single register stage:
  - in_ready = !out_valid | out_ready.
  - Transfer occurs when in_valid & in_ready; its result appears on outputs the next cycle (latency 1).
  - Full throughput under continuous out_ready=1.
- Hold: while out_valid & !out_ready, all out_* are stable and the next input is not accepted.
- Drain: if out_ready=1 and no transfer, out_valid falls to 0 next cycle.
- Flush: takes priority over transfer. Next cycle out_valid=0, and the same-cycle input is consumed and discarded. Data registers may retain stale values.
- Reset mid-transfer: reset wins, and the entry is lost.
- Decode (opcode = instr[6:0]):
  - 0010011 OP-IMM: funct3 001/101 (shifts) give fmt I with imm = zero-extended shamt. Shamt is instr[24:20] when XLEN=32 (illegal if instr[25]=1) and instr[25:20] when XLEN=64. All other funct3 values give fmt I with the sign-extended 12-bit immediate.
  - 0011011 OP-IMM-32: legal only when XLEN=64. Same as OP-IMM except shamt is always 5 bits.
  - 0000011 load, 1100111 JALR, 0001111 FENCE: fmt I.
  - 1110011 SYSTEM: funct3[2]=1 gives fmt ZIMM with imm = zero-extended instr[19:15]; otherwise fmt I.
  - 0100011: fmt S.
  - 1100011: fmt B, imm[0]=0.
  - 0110111 LUI, 0010111 AUIPC: fmt U, {instr[31:12], 12'b0} sign-extended from bit 31 to XLEN.
  - 1101111: fmt J, imm[0]=0.
  - 0110011 OP, 0111011 OP-32 (XLEN=64 only): fmt NONE, imm=0.
  - Anything else: fmt ILLEGAL, imm=0, out_illegal=1, target=0.
- Sign extension: every I/S/B/J/U immediate is sign-extended from instr[31] to the full XLEN.
- Target: out_target = in_pc + out_imm modulo 2^XLEN, for fmt B, fmt J, and AUIPC only; 0 otherwise, including for LUI.

Test Plan:
- ADDI 0xFFF00093, XLEN=32 -> one cycle later: out_imm=0xFFFFFFFF, fmt=1, target=0, illegal=0.
- BEQ 0xFE000EE3 with pc=0x00000100 -> imm=0xFFFFFFFC, fmt=3, target=0x000000FC. JAL 0x0000006F with pc=0xFFFFFFFC -> imm=0, target=0xFFFFFFFC, checking wrap.
- XLEN=64:
  - LUI 0x800000B7 -> imm=0xFFFFFFFF80000000, target=0.
  - SLLI 0x03F09093 -> imm=0x3F, fmt=1.
  - The same SLLI with XLEN=32 -> fmt=7, illegal=1, imm=0.
- CSRRWI 0x300FD073 -> imm=0x0000001F, fmt=6. Instruction 0x00000000 -> fmt=7, illegal=1.
- Backpressure:
  - Push A, B back-to-back with out_ready=0 -> in_ready=0 after A is captured, and A is held stable 5 cycles.
  - Raise out_ready -> B appears exactly next cycle, with no loss or duplication.
  - A 100-instruction random stream with random ready is checked against a reference model.
- Flush asserted with in_valid=1 while holding an entry -> out_valid=0 next cycle and the flushed input never appears. rst_n low mid-stream -> all outputs 0 immediately, in_ready=1.
